// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and its pending-write scoreboard.
// Holds the width helper, the counter update encoding and the register reset value.
package regfile_scoreboard_pkg;

    localparam int REG_RST_VAL = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    // Net effect of one cycle's inc/dec events on a single register's count
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC1 = 2'd2,
        CNT_DEC2 = 2'd3
    } cnt_op_e;

    function automatic cnt_op_e cnt_op(input logic inc, input logic dec_wb, input logic dec_sq);
        logic [1:0] ndec;
        ndec = {1'b0, dec_wb} + {1'b0, dec_sq};
        case ({inc, ndec})
            3'b0_00, 3'b1_01: return CNT_HOLD;
            3'b1_00:          return CNT_INC;
            3'b0_01, 3'b1_10: return CNT_DEC1;
            default:          return CNT_DEC2;
        endcase
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode-side bundle of the register file: read ports, issue, writeback, squash and status.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_REGS     = 8,
    parameter int NUM_RD       = 2,
    parameter int MAX_INFLIGHT = 3
);
    localparam int AW = clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_sel;
    logic [NUM_RD-1:0]        rd_use;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     issue_valid;
    logic                     issue_wr_en;
    logic [AW-1:0]            issue_wr_sel;
    logic                     stall;
    logic                     issued;
    logic                     wb_en;
    logic [AW-1:0]            wb_sel;
    logic [DATA_W-1:0]        wb_data;
    logic                     sq_en;
    logic [AW-1:0]            sq_sel;
    logic [NUM_REGS-1:0]      pending;
    logic                     err;

    modport master (
        output rd_sel, rd_use, issue_valid, issue_wr_en, issue_wr_sel,
               wb_en, wb_sel, wb_data, sq_en, sq_sel,
        input  rd_data, stall, issued, pending, err
    );

    modport slave (
        input  rd_sel, rd_use, issue_valid, issue_wr_en, issue_wr_sel,
               wb_en, wb_sel, wb_data, sq_en, sq_sel,
        output rd_data, stall, issued, pending, err
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-write counter for one register; clamps at 0 and MAX_INFLIGHT and flags either event.
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int CW           = clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_wb_i,
    input  logic          dec_sq_i,
    output logic [CW-1:0] cnt_o,
    output logic          nz_o,
    output logic          flag_o
);
    localparam logic signed [CW+1:0] MAX_S = (CW+2)'(MAX_INFLIGHT);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [CW+1:0] sum;

    function automatic logic signed [CW+1:0] op_delta(input cnt_op_e op);
        case (op)
            CNT_INC:  return (CW+2)'(1);
            CNT_DEC1: return (CW+2)'(-1);
            CNT_DEC2: return (CW+2)'(-2);
            default:  return '0;
        endcase
    endfunction

    // Returns {flag, count}: flag marks a result clamped at either bound
    function automatic logic [CW:0] sat_cnt(input logic signed [CW+1:0] s);
        if (s < 0)          return {1'b1, {CW{1'b0}}};
        else if (s > MAX_S) return {1'b1, CW'(MAX_INFLIGHT)};
        else                return {1'b0, s[CW-1:0]};
    endfunction

    always_comb begin
        sum = $signed({2'b00, cnt_q}) + op_delta(cnt_op(inc_i, dec_wb_i, dec_sq_i));
        {flag_o, cnt_d} = sat_cnt(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign nz_o  = |cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-port writeback bypass and a per-register
// pending-write scoreboard that stalls issue on RAW and in-flight-depth hazards.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_REGS     = 8,
    parameter int NUM_RD       = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = clog2(NUM_REGS);
    localparam int CW = clog2(MAX_INFLIGHT + 1);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [CW-1:0]            cnt    [NUM_REGS];
    logic [NUM_REGS-1:0]      nz, flag, inc, dec_wb, dec_sq;
    logic                     err_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic                     hazard, struct_haz, stall_c, issued_c, wdec;
    logic [AW-1:0]            sel;
    logic                     byp;

    // Bypass is suppressed while in reset so reads return cleared state immediately
    always_comb begin
        rd_data_c = '0;
        hazard    = 1'b0;
        sel       = '0;
        byp       = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            sel = bus.rd_sel[i*AW +: AW];
            byp = rst_n & bus.wb_en & (bus.wb_sel == sel);
            rd_data_c[i*DATA_W +: DATA_W] = byp ? bus.wb_data : regs_q[sel];
            if (bus.rd_use[i] && (cnt[sel] != '0) && !(byp && (cnt[sel] == CW'(1))))
                hazard = 1'b1;
        end
        wdec = (bus.wb_en & (bus.wb_sel == bus.issue_wr_sel))
             | (bus.sq_en & (bus.sq_sel == bus.issue_wr_sel));
        struct_haz = bus.issue_wr_en & (cnt[bus.issue_wr_sel] == CW'(MAX_INFLIGHT)) & ~wdec;
        stall_c    = bus.issue_valid & (hazard | struct_haz);
        issued_c   = rst_n & bus.issue_valid & ~stall_c;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc[r]    = issued_c & bus.issue_wr_en & (bus.issue_wr_sel == AW'(r));
        assign dec_wb[r] = bus.wb_en & (bus.wb_sel == AW'(r));
        assign dec_sq[r] = bus.sq_en & (bus.sq_sel == AW'(r));

        sb_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CW           (CW)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc_i    (inc[r]),
            .dec_wb_i (dec_wb[r]),
            .dec_sq_i (dec_sq[r]),
            .cnt_o    (cnt[r]),
            .nz_o     (nz[r]),
            .flag_o   (flag[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= DATA_W'(REG_RST_VAL);
            err_q <= 1'b0;
        end else begin
            if (bus.wb_en) regs_q[bus.wb_sel] <= bus.wb_data;
            err_q <= err_q | (|flag);
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.stall   = stall_c;
    assign bus.issued  = issued_c;
    assign bus.pending = nz;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by random traffic,
// each cycle compared against an array-based model of the register/scoreboard rules.
module tb_regfile_scoreboard;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int NP = 2;
    localparam int MI = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int   mregs [NR];
    int   mcnt  [NR];
    bit   merr;

    regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP), .MAX_INFLIGHT(MI)) bus ();

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP), .MAX_INFLIGHT(MI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd_sel = '0; bus.rd_use = '0;
        bus.issue_valid = 0; bus.issue_wr_en = 0; bus.issue_wr_sel = '0;
        bus.wb_en = 0; bus.wb_sel = '0; bus.wb_data = '0;
        bus.sq_en = 0; bus.sq_sel = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin mregs[r] = 0; mcnt[r] = 0; end
        merr = 0;
    endtask

    function automatic bit wb_hits(int r);
        return rst_n && bus.wb_en && (int'(bus.wb_sel) == r);
    endfunction

    function automatic int exp_rd(int i);
        int s;
        s = int'(bus.rd_sel[i*3 +: 3]);
        return wb_hits(s) ? int'(bus.wb_data) : mregs[s];
    endfunction

    function automatic bit exp_stall();
        bit h;
        int s, w;
        h = 0;
        for (int i = 0; i < NP; i++) begin
            s = int'(bus.rd_sel[i*3 +: 3]);
            if (bus.rd_use[i] && mcnt[s] > 0 && !(wb_hits(s) && mcnt[s] == 1)) h = 1;
        end
        w = int'(bus.issue_wr_sel);
        if (bus.issue_wr_en && mcnt[w] == MI && !(wb_hits(w) || (bus.sq_en && int'(bus.sq_sel) == w)))
            h = 1;
        return bus.issue_valid && h;
    endfunction

    function automatic logic [7:0] exp_pending();
        logic [7:0] p;
        for (int r = 0; r < NR; r++) p[r] = (mcnt[r] > 0);
        return p;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step(input string tag);
        bit st, iss;
        int n;
        #1;
        st  = exp_stall();
        iss = bus.issue_valid && !st;
        for (int i = 0; i < NP; i++)
            chk($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_data[i*DW +: DW]), 32'(exp_rd(i)));
        chk({tag, "_stall"}, 32'(bus.stall), 32'(st));
        chk({tag, "_issued"}, 32'(bus.issued), 32'(iss));
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            n = mcnt[r];
            if (iss && bus.issue_wr_en && int'(bus.issue_wr_sel) == r) n++;
            if (bus.wb_en && int'(bus.wb_sel) == r) n--;
            if (bus.sq_en && int'(bus.sq_sel) == r) n--;
            if (n < 0)  begin n = 0;  merr = 1; end
            if (n > MI) begin n = MI; merr = 1; end
            mcnt[r] = n;
        end
        if (bus.wb_en) mregs[bus.wb_sel] = int'(bus.wb_data);
        chk({tag, "_pending"}, 32'(bus.pending), 32'(exp_pending()));
        chk({tag, "_err"}, 32'(bus.err), 32'(merr));
        @(negedge clk);
    endtask

    task automatic issue_wr(input int r, input string tag);
        idle();
        bus.issue_valid = 1; bus.issue_wr_en = 1; bus.issue_wr_sel = 3'(r);
        step(tag);
    endtask

    initial begin
        int r;
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_issued", 32'(bus.issued), 32'h0);
        rst_n = 1;
        @(negedge clk);

        // Writeback, registered read and same-cycle bypass
        issue_wr(3, "iw3");
        issue_wr(5, "iw5");
        idle(); bus.wb_en = 1; bus.wb_sel = 3; bus.wb_data = 16'h1234; step("wb3");
        idle(); bus.rd_sel = {3'd0, 3'd3}; step("rd3");
        idle(); bus.rd_sel = {3'd5, 3'd3}; bus.wb_en = 1; bus.wb_sel = 5; bus.wb_data = 16'hBEEF;
        step("byp5");

        // RAW hazard on r2, then last-pending bypass clears it
        issue_wr(2, "iw2");
        idle(); bus.issue_valid = 1; bus.rd_use = 2'b01; bus.rd_sel = {3'd0, 3'd2}; step("raw2");
        idle(); bus.issue_valid = 1; bus.rd_use = 2'b00; bus.rd_sel = {3'd0, 3'd2}; step("nouse2");
        idle(); bus.issue_valid = 1; bus.rd_use = 2'b01; bus.rd_sel = {3'd0, 3'd2};
        bus.wb_en = 1; bus.wb_sel = 2; bus.wb_data = 16'h00AA; step("wbbyp2");

        // Depth limit on r4
        issue_wr(4, "iw4a");
        issue_wr(4, "iw4b");
        issue_wr(4, "iw4c");
        issue_wr(4, "full4");
        idle(); bus.issue_valid = 1; bus.issue_wr_en = 1; bus.issue_wr_sel = 4;
        bus.wb_en = 1; bus.wb_sel = 4; bus.wb_data = 16'h4444; step("full4wb");
        issue_wr(4, "still4");
        for (int k = 0; k < 3; k++) begin
            idle(); bus.wb_en = 1; bus.wb_sel = 4; bus.wb_data = 16'(k); step("drain4");
        end

        // Summed events on r6, then underflow makes err sticky
        issue_wr(6, "iw6");
        idle(); bus.issue_valid = 1; bus.issue_wr_en = 1; bus.issue_wr_sel = 6;
        bus.wb_en = 1; bus.wb_sel = 6; bus.wb_data = 16'h6666; bus.sq_en = 1; bus.sq_sel = 6;
        step("sum6");
        idle(); bus.sq_en = 1; bus.sq_sel = 6; step("under6");
        idle(); step("sticky");

        // Asynchronous reset in the middle of a cycle
        issue_wr(1, "iw1a");
        issue_wr(1, "iw1b");
        idle(); bus.issue_valid = 1; bus.rd_use = 2'b11; bus.rd_sel = {3'd3, 3'd1};
        #3;
        rst_n = 0;
        model_reset();
        #1;
        chk("arst_pending", 32'(bus.pending), 32'h0);
        chk("arst_stall", 32'(bus.stall), 32'h0);
        chk("arst_issued", 32'(bus.issued), 32'h0);
        chk("arst_err", 32'(bus.err), 32'h0);
        chk("arst_rd0", 32'(bus.rd_data[0 +: DW]), 32'h0);
        chk("arst_rd1", 32'(bus.rd_data[DW +: DW]), 32'h0);
        @(negedge clk);
        rst_n = 1;
        idle();
        @(negedge clk);

        // Random traffic; retirements mostly target registers that are actually pending
        for (int c = 0; c < 300; c++) begin
            idle();
            bus.rd_sel = 6'($urandom);
            bus.rd_use = 2'($urandom);
            bus.issue_valid = 1'($urandom);
            bus.issue_wr_en = 1'($urandom);
            bus.issue_wr_sel = 3'($urandom);
            r = int'($urandom_range(0, NR - 1));
            if (mcnt[r] > 0 && $urandom_range(0, 2) != 0) begin
                bus.wb_en = 1; bus.wb_sel = 3'(r); bus.wb_data = 16'($urandom);
            end
            r = int'($urandom_range(0, NR - 1));
            if (mcnt[r] > 1 && $urandom_range(0, 5) == 0) begin
                bus.sq_en = 1; bus.sq_sel = 3'(r);
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file with bypass.
- Holds the architectural register file and provides NUM_RD read ports, each with write-to-read bypass.
- Adds a per-register pending-write scoreboard that raises a RAW-hazard stall toward fetch/decode.
- Replaces the fixed two-read, single-depth arrangement. Sits in decode; writeback arrives from the WB stage, and squash notifications come from branch resolution.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of architectural registers (power of 2, >=2)
- NUM_RD, 2, number of read ports (1..4)
- MAX_INFLIGHT, 3, maximum pending writes per register (decode-to-WB distance)
- AW = clog2(NUM_REGS), derived localparam
- CW = clog2(MAX_INFLIGHT+1), derived localparam

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_sel  in  NUM_RD*AW  read register selects; port i occupies bits [i*AW +: AW]
- rd_use  in  NUM_RD  port i is a real source operand (it participates in hazard check)
- rd_data  out  NUM_RD*DATA_W  read data, combinational, bypassed
- issue_valid  in  1  decode presents an instruction this cycle
- issue_wr_en  in  1  that instruction will write a register
- issue_wr_sel  in  AW  its destination register
- stall  out  1  hold decode/fetch; the instruction is not issued
- issued  out  1  issue_valid & ~stall (instruction accepted)
- wb_en  in  1  writeback strobe
- wb_sel  in  AW  writeback register
- wb_data  in  DATA_W  writeback data
- sq_en  in  1  an in-flight writer was squashed (flushed before WB)
- sq_sel  in  AW  destination of the squashed writer
- pending  out  NUM_REGS  bit r = scoreboard count of r is non-zero
- err  out  1  sticky scoreboard error

Behaviour:
- Reset (rst_n low, async): all registers 0, all counts 0, err 0. Outputs during reset: stall 0, issued 0, pending 0.
- Read: rd_data[i] = wb_data if wb_en & wb_sel==rd_sel[i]; otherwise regs[rd_sel[i]]. Zero latency. All NUM_REGS registers are general; none is hardwired to 0.
- Write: on the edge with wb_en, regs[wb_sel] <= wb_data.
- Hazard for port i: rd_use[i] & cnt[rd_sel[i]] != 0, unless wb_en & wb_sel==rd_sel[i] & cnt==1 (last pending write is being bypassed this cycle, so no hazard).
- Structural hazard: issue_wr_en & cnt[issue_wr_sel]==MAX_INFLIGHT & ~(wb/sq decrementing that register this cycle).
- stall = issue_valid & (any port hazard | structural hazard). Combinational; no state machine beyond the counters.
- Count update per register r, on each edge: net = +1 if issued & issue_wr_en & issue_wr_sel==r; -1 if wb_en & wb_sel==r; -1 if sq_en & sq_sel==r.
- Simultaneous events on the same register are summed in one cycle: +1-1-1 gives -1 net; +1-1 leaves the count unchanged.
- Underflow: a decrement that would take a count below 0 clamps it at 0 and sets err.
- Overflow cannot occur because of the structural stall; if forced anyway, the count saturates at MAX_INFLIGHT and err is set.
- err is sticky until reset. A data write on an unmatched wb_en still occurs.
- pending[r] = |cnt[r]; it is registered state.
- Reset asserted mid-operation clears everything at once; no writeback is retained.

Decomposition:
- Shared package: AW/CW derivation function (clog2), the counter update encoding, and the reset value constant for registers.
- One natural sub-module: sb_counter (one per register, generate loop). Inputs inc, dec_wb, dec_sq; outputs cnt, nz, and an under/overflow flag.
- Register array, bypass muxes and stall logic stay in the top module.

Test Plan:
- Reset, then wb r3=0x1234 → next cycle rd_sel[0]=3 reads 0x1234. Same-cycle wb r5=0xBEEF with rd_sel[1]=5 returns 0xBEEF combinationally.
- Issue a writer to r2 (cnt 1). Next cycle, a reader with rd_use[0]=1, rd_sel[0]=2 → stall=1, issued=0. With rd_use[0]=0 → no stall.
- r2 at cnt=1, wb r2=0x00AA in the same cycle as the reader → stall=0, rd_data=0x00AA; cnt goes to 0.
- Three writers to r4 (cnt=3=MAX_INFLIGHT), then a fourth writer → stall=1. Same cycle with wb r4 → no stall, cnt stays 3.
- r6 cnt=1; in one cycle, issue writer r6 + wb r6 + sq r6 → cnt 0, err=0. A further sq r6 → cnt 0, err=1 and held until rst_n low.
- With cnt r1=2, assert rst_n low asynchronously mid-cycle → pending=0, stall=0, and all reads return 0 immediately.
